// File: rtl/sample_queue.sv
// sample_queue
//   Stereo sample history buffer. Every strobed {left,right} pair is written
//   into a DEPTH-entry circular buffer. Once TAPS samples have been seen, a
//   write that arrives while no readout is running triggers a readout of the
//   newest TAPS samples, oldest first, one pair per clock.
//
// Parameters
//   DEPTH : buffer entries, power of two
//   TAPS  : samples per readout sequence, TAPS < DEPTH
//
// Ports
//   clk        : clock, all state on rising edge
//   rst_n      : asynchronous active-low reset
//   new_smpl   : one-cycle strobe, sample pair present on lft_smpl/rght_smpl
//   lft_smpl   : left sample in (signed 16)
//   rght_smpl  : right sample in (signed 16)
//   sequencing : high while the readout sequence is on lft_out/rght_out
//   lft_out    : left sample out (signed 16), holds when not sequencing
//   rght_out   : right sample out (signed 16), holds when not sequencing
//   overrun    : one-cycle pulse after a write accepted during a readout;
//                present only when SAMPLE_QUEUE_OVERRUN_EN is defined
//
// Build option
//   SAMPLE_QUEUE_OVERRUN_EN : adds the overrun port and its logic.
module sample_queue #(
  parameter int DEPTH = 1024,
  parameter int TAPS  = 1021
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               new_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out
`ifdef SAMPLE_QUEUE_OVERRUN_EN
  ,
  output logic               overrun
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, SEQ} state_t;

  state_t             r_state;
  logic [31:0]        r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_seq_cnt;
  logic               r_sequencing;
  logic signed [15:0] r_lft;
  logic signed [15:0] r_rght;

  logic [CW-1:0]      w_count_inc;
  logic               w_full_after;

  // Fill count saturates at TAPS; it only ever answers "is the history full".
  assign w_count_inc  = (r_count == CW'(TAPS)) ? r_count : r_count + 1'b1;
  assign w_full_after = (w_count_inc == CW'(TAPS));

  // Storage is not reset: no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (new_smpl) r_mem[r_wptr] <= {lft_smpl, rght_smpl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_seq_cnt    <= '0;
      r_sequencing <= 1'b0;
      r_lft        <= '0;
      r_rght       <= '0;
    end else begin
      // Writes are accepted in every state.
      if (new_smpl) begin
        r_wptr  <= r_wptr + 1'b1;
        r_count <= w_count_inc;
      end

      case (r_state)
        IDLE, FILL: begin
          r_sequencing <= 1'b0;
          if (new_smpl) r_state <= w_full_after ? LAUNCH : FILL;
        end
        LAUNCH: begin
          // r_wptr already points past the triggering sample, so stepping
          // back TAPS entries lands on the oldest sample of the window.
          r_sequencing <= 1'b0;
          r_rptr       <= r_wptr - AW'(TAPS);
          r_seq_cnt    <= '0;
          r_state      <= SEQ;
        end
        SEQ: begin
          // The output register is the read data register, so data and
          // sequencing change on the same edge.
          {r_lft, r_rght} <= r_mem[r_rptr];
          r_sequencing    <= 1'b1;
          r_rptr          <= r_rptr + 1'b1;
          r_seq_cnt       <= r_seq_cnt + 1'b1;
          if (r_seq_cnt == CW'(TAPS - 1)) r_state <= FILL;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SAMPLE_QUEUE_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_overrun <= 1'b0;
    else        r_overrun <= new_smpl && (r_state == LAUNCH || r_state == SEQ);
  end

  assign overrun = r_overrun;
`endif

  assign sequencing = r_sequencing;
  assign lft_out    = r_lft;
  assign rght_out   = r_rght;

endmodule

// File: tb/tb_sample_queue.sv
module tb_sample_queue;

  localparam int DEPTH = 1024;
  localparam int TAPS  = 1021;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               new_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
`ifdef SAMPLE_QUEUE_OVERRUN_EN
  logic               overrun;
`endif

  sample_queue #(.DEPTH(DEPTH), .TAPS(TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .new_smpl   (new_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out)
`ifdef SAMPLE_QUEUE_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: full sample history since reset, plus expectation queues.
  logic [31:0] hist[$];
  logic [31:0] exp_q[$];
  int          start_q[$];
  int          ovr_q[$];
  int          busy_end = -100;
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void bad(string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endfunction

  // Write one pair; returns at 1ns after the edge that sampled it.
  task automatic wr_raw(input logic [15:0] l, input logic [15:0] r);
    int k;
    new_smpl  = 1'b1;
    lft_smpl  = l;
    rght_smpl = r;
    @(posedge clk);
    #1;
    k = cyc;
    new_smpl = 1'b0;
    hist.push_back({l, r});
    if (k <= busy_end) begin
`ifdef SAMPLE_QUEUE_OVERRUN_EN
      ovr_q.push_back(k + 1);
`endif
    end else if (hist.size() >= TAPS) begin
      for (int i = hist.size() - TAPS; i < hist.size(); i++) exp_q.push_back(hist[i]);
      start_q.push_back(k + 2);
      busy_end = k + 1 + TAPS;
    end
  endtask

  task automatic wr(input int n);
    wr_raw(16'(n), 16'(-n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || cyc <= busy_end + 1) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (t >= 5000) bad("wait_idle_timeout");
    idle(2);
  endtask

  // Monitor: pops expected data whenever the DUT presents a sequence.
  logic        prev_seq = 1'b0;
  int          run_len  = 0;
  logic [31:0] last_out = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_seq = 1'b0;
      run_len  = 0;
      last_out = '0;
      chk("reset_seq", {31'b0, sequencing}, 32'd0);
      chk("reset_out", {lft_out, rght_out}, 32'd0);
    end else begin
      if (sequencing) begin
        if (!prev_seq) begin
          if (start_q.size() == 0) bad("seq_unexpected_start");
          else chk("seq_start_cycle", cyc, start_q.pop_front());
        end
        run_len++;
        if (exp_q.size() == 0) bad("seq_unexpected_data");
        else begin
          last_out = exp_q.pop_front();
          chk("seq_data", {lft_out, rght_out}, last_out);
        end
      end else begin
        if (prev_seq) chk("seq_length", run_len, TAPS);
        run_len = 0;
        chk("hold_out", {lft_out, rght_out}, last_out);
      end
      prev_seq = sequencing;
`ifdef SAMPLE_QUEUE_OVERRUN_EN
      begin
        logic e;
        while (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
          void'(ovr_q.pop_front());
          chk("overrun_missed", 32'd0, 32'd1);
        end
        e = (ovr_q.size() > 0 && ovr_q[0] == cyc);
        if (e) void'(ovr_q.pop_front());
        if (e || overrun) chk("overrun", {31'b0, overrun}, {31'b0, e});
      end
`endif
    end
  end

  initial begin
    rst_n     = 1'b0;
    new_smpl  = 1'b0;
    lft_smpl  = '0;
    rght_smpl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sequencing", {31'b0, sequencing}, 32'd0);
    chk("rst_lft", {16'b0, lft_out}, 32'd0);
    chk("rst_rght", {16'b0, rght_out}, 32'd0);
`ifdef SAMPLE_QUEUE_OVERRUN_EN
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to one short of TAPS with random spacing, then trigger.
    for (int n = 1; n <= TAPS - 1; n++) begin
      wr(n);
      idle($urandom_range(0, 3));
    end
    idle(50);
    wr(TAPS);
    wait_idle();

    // Next write re-triggers; writes during that readout only get stored.
    wr(1022);
    idle(5);
    for (int n = 1023; n <= 1099; n++) begin
      wr(n);
      idle($urandom_range(0, 2));
    end
    wait_idle();
    wr(1100);
    wait_idle();

    // Write 500 cycles into a readout: stored, not queued.
    wr(1101);
    idle(499);
    wr(1102);
    wait_idle();
    wr(1103);
    wait_idle();

    // Reset while output 600 is presented.
    wr(1104);
    repeat (601) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    start_q.delete();
    ovr_q.delete();
    hist.delete();
    busy_end = -100;
    #1;
    chk("midseq_rst_seq", {31'b0, sequencing}, 32'd0);
    chk("midseq_rst_out", {lft_out, rght_out}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Refill with random sample values.
    for (int n = 1; n <= TAPS - 1; n++) begin
      wr_raw(16'($urandom), 16'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(50);
    wr_raw(16'($urandom), 16'($urandom));
    wait_idle();

    chk("exp_data_drained", exp_q.size(), 0);
    chk("exp_start_drained", start_q.size(), 0);
    chk("exp_overrun_drained", ovr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
